// File: rtl/tc_fma_acc_stage.sv
// Two-stage fused multiply-add / group accumulate stage behind the Toom-Cook multiplier.
// Define TC_FMA_SAT_EN to clamp overflowing sums to all-ones (default: wrap modulo 2^ACC_W).
module tc_fma_acc_stage #(
  parameter int PROD_W = 22,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [ACC_W-1:0]  in_addend,
  input  logic              in_acc_mode,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;
  localparam int ZEXT_W = ACC_W - PROD_W + 1;

  logic              stall;

  logic              a_vld_q;
  logic [PROD_W-1:0] a_prod_q;
  logic [ACC_W-1:0]  a_addend_q;
  logic              a_mode_q;
  logic              a_last_q;

  logic [0:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sticky_q, sticky_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic              out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum_full;
  logic              carry;
  logic [ACC_W-1:0]  res;
  logic              produce;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Stage A: beat capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q <= 1'b0;
    end else if (!stall) begin
      a_vld_q <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_prod_q   <= '0;
      a_addend_q <= '0;
      a_mode_q   <= 1'b0;
      a_last_q   <= 1'b0;
    end else if (!stall && in_valid) begin
      a_prod_q   <= in_prod;
      a_addend_q <= in_addend;
      a_mode_q   <= in_acc_mode;
      a_last_q   <= in_last;
    end
  end

  // Only accumulate beats inside an open group take the running total as base.
  assign base     = (a_mode_q && (state_q == ST_ACCUM)) ? acc_q : a_addend_q;
  assign sum_full = {1'b0, base} + {{ZEXT_W{1'b0}}, a_prod_q};
  assign carry    = sum_full[ACC_W];
`ifdef TC_FMA_SAT_EN
  assign res      = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign res      = sum_full[ACC_W-1:0];
`endif
  assign produce  = a_vld_q & (~a_mode_q | a_last_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    if (!stall) begin
      out_valid_d = produce;
      if (produce) begin
        out_sum_d = res;
        out_ovf_d = carry | (a_mode_q & sticky_q);
      end
      if (a_vld_q && a_mode_q) begin
        if (a_last_q) begin
          acc_d    = '0;
          state_d  = ST_IDLE;
          sticky_d = 1'b0;
        end else begin
          acc_d    = res;
          state_d  = ST_ACCUM;
          sticky_d = sticky_q | carry;
        end
      end
    end
  end

  // Stage B: accumulator, group state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_tc_fma_acc_stage.sv
// Directed bench for tc_fma_acc_stage; expected values hand-computed for PROD_W=22, ACC_W=24.
module tb_tc_fma_acc_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [21:0] in_prod = '0;
  logic [23:0] in_addend = '0;
  logic        in_acc_mode = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_sum;
  logic        out_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt = 0;
  int rdy_viol = 0;
  logic [23:0] q_sum[$];
  logic        q_ovf[$];

  tc_fma_acc_stage #(.PROD_W(22), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_addend(in_addend),
    .in_acc_mode(in_acc_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Outputs are sampled mid-cycle; a transfer completes at the following rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_sum.push_back(out_sum);
      q_ovf.push_back(out_ovf);
    end
    if (out_valid && !out_ready) begin
      stall_cnt++;
      if (in_ready) rdy_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [21:0] p, input logic [23:0] a, input logic m, input logic l);
    int n;
    logic took;
    n = 0;
    took = 1'b0;
    in_valid = 1'b1; in_prod = p; in_addend = a; in_acc_mode = m; in_last = l;
    while (!took && n < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!took) chk("send_timeout", 32'(took), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_test();
    q_sum.delete();
    q_ovf.delete();
  endtask

  task automatic chk_result(input string tag, input int idx, input logic [23:0] s, input logic o);
    if (q_sum.size() > idx) begin
      chk({tag, "_sum"}, 32'(q_sum[idx]), 32'(s));
      chk({tag, "_ovf"}, 32'(q_ovf[idx]), 32'(o));
    end else begin
      chk({tag, "_missing"}, 32'(q_sum.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // FMA latency and bubble drop
    start_test();
    in_valid = 1'b1; in_prod = 22'h3FF001; in_addend = 24'h000FFF; in_acc_mode = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fma_lat_n1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("fma_lat_n2_valid", 32'(out_valid), 32'd1);
    chk("fma_sum", 32'(out_sum), 32'h400000);
    chk("fma_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bubble_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Four-beat accumulate group; addend of non-seed beats must be ignored
    start_test();
    send(22'h3FF001, 24'h000000, 1'b1, 1'b0);
    send(22'h3FF001, 24'h000123, 1'b1, 1'b0);
    send(22'h3FF001, 24'h000456, 1'b1, 1'b0);
    send(22'h3FF001, 24'h000789, 1'b1, 1'b1);
    idle(4);
    chk("acc_count", 32'(q_sum.size()), 32'd1);
    chk_result("acc", 0, 24'hFFC004, 1'b0);

    // Group overflow
    start_test();
    send(22'h3FF001, 24'h004000, 1'b1, 1'b0);
    repeat (2) send(22'h3FF001, 24'h0, 1'b1, 1'b0);
    send(22'h3FF001, 24'h0, 1'b1, 1'b1);
    idle(4);
    chk("ovfg_count", 32'(q_sum.size()), 32'd1);
`ifdef TC_FMA_SAT_EN
    chk_result("ovfg", 0, 24'hFFFFFF, 1'b1);
`else
    chk_result("ovfg", 0, 24'h000004, 1'b1);
`endif

    // FMA overflow and sticky flag on a later non-carrying beat
    start_test();
    send(22'h3FFFFF, 24'hFFFFFF, 1'b0, 1'b0);
    send(22'h000001, 24'hFFFFFF, 1'b1, 1'b0);
    send(22'h000005, 24'h000000, 1'b1, 1'b1);
    idle(4);
`ifdef TC_FMA_SAT_EN
    chk_result("fma_ovf", 0, 24'hFFFFFF, 1'b1);
    chk_result("sticky", 1, 24'hFFFFFF, 1'b1);
`else
    chk_result("fma_ovf", 0, 24'h3FFFFE, 1'b1);
    chk_result("sticky", 1, 24'h000005, 1'b1);
`endif
    // Sticky flag must be gone for the next group
    start_test();
    send(22'h000002, 24'h000003, 1'b1, 1'b1);
    idle(4);
    chk_result("sticky_clr", 0, 24'h000005, 1'b0);

    // Interleaved FMA inside an open group
    start_test();
    send(22'd10, 24'd100, 1'b1, 1'b0);
    send(22'd3, 24'd4, 1'b0, 1'b1);
    send(22'd20, 24'd999, 1'b1, 1'b1);
    idle(4);
    chk("intl_count", 32'(q_sum.size()), 32'd2);
    chk_result("intl_fma", 0, 24'd7, 1'b0);
    chk_result("intl_grp", 1, 24'd130, 1'b0);

    // Backpressure with a continuous stream
    start_test();
    stall_cnt = 0;
    rdy_viol = 0;
    fork
      for (int i = 0; i < 6; i++) send(22'(i + 1), 24'(i * 256), 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    chk("bp_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("bp_in_ready_viol", 32'(rdy_viol), 32'd0);
    chk("bp_count", 32'(q_sum.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_result("bp", i, 24'(i * 256 + i + 1), 1'b0);

    // Reset in the middle of a group, with a beat offered during reset
    start_test();
    send(22'h000111, 24'h000222, 1'b1, 1'b0);
    send(22'h000111, 24'h000222, 1'b1, 1'b0);
    in_valid = 1'b1; in_prod = 22'd99; in_addend = 24'd1; in_acc_mode = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(4);
    chk("midrst_no_output", 32'(q_sum.size()), 32'd0);
    send(22'd7, 24'd5, 1'b1, 1'b1);
    idle(4);
    chk_result("midrst_grp", 0, 24'd12, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
